// File: rtl/io_hub_pkg.sv
// Register map of the 6809 I/O hub page, shared by the hub and by any
// block that needs to decode the same offsets.
package io_hub_pkg;

    localparam logic [7:0] OFS_STROBE   = 8'h00;
    localparam logic [7:0] OFS_LATCH    = 8'h40;
    localparam logic [7:0] OFS_PRNG_CTL = 8'h60;
    localparam logic [7:0] OFS_RD_PRNG  = 8'h80;
    localparam logic [7:0] OFS_RD_STAT  = 8'h81;
    localparam logic [7:0] OFS_RD_LATCH = 8'h82;

endpackage

// File: rtl/sync_rise.sv
// Multi-flop synchroniser for an asynchronous level, with a one-cycle
// pulse on each synchronised rising edge.
module sync_rise #(
    parameter int DEPTH = 3
) (
    input  logic clk_12,
    input  logic reset_n,
    input  logic d,
    output logic sync,
    output logic rise
);

    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "sync_rise: DEPTH must be at least 2");
    end

    logic [DEPTH-1:0] stages;
    logic             sync_d;

    always_ff @(posedge clk_12 or negedge reset_n) begin
        if (!reset_n) begin
            stages <= '0;
            sync_d <= 1'b0;
        end else begin
            stages <= {stages[DEPTH-2:0], d};
            sync_d <= stages[DEPTH-1];
        end
    end

    assign sync = stages[DEPTH-1];
    assign rise = stages[DEPTH-1] & ~sync_d;

endmodule

// File: rtl/cpu_io_hub_gen.sv
// Memory-mapped I/O hub on the 6809 bus: write strobes, control latches,
// LFSR PRNG and a busy flag cleared by the vector generator's done level.
module cpu_io_hub_gen
    import io_hub_pkg::*;
#(
    parameter int                ADDR_W       = 16,
    parameter int                DATA_W       = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 16'h4600,
    parameter int                NUM_STROBE   = 4,
    parameter int                NUM_LATCH    = 8,
    parameter int                LFSR_W       = 24,
    parameter int                LFSR_TAP_A   = 5,
    parameter int                LFSR_TAP_B   = 22,
    parameter int                PRNG_OUT_LSB = 8,
    parameter int                LFSR_DIV     = 4
) (
    input  logic                  clk_12,
    input  logic                  reset_n,
    input  logic                  cpu_e,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic                  cpu_rnw,
    input  logic [DATA_W-1:0]     cpu_dout,
    input  logic                  done_in,
    output logic [DATA_W-1:0]     cpu_din_q,
    output logic                  cpu_rd_hit,
    output logic [NUM_STROBE-1:0] strobe,
    output logic [NUM_LATCH-1:0]  latch_q,
    output logic                  busy
);

    if (NUM_STROBE < 1 || NUM_STROBE > 32) begin : g_bad_strobe
        $fatal(1, "cpu_io_hub_gen: NUM_STROBE must be 1..32");
    end
    if (NUM_LATCH < 1 || NUM_LATCH > 32) begin : g_bad_latch
        $fatal(1, "cpu_io_hub_gen: NUM_LATCH must be 1..32");
    end
    if (LFSR_TAP_A >= LFSR_W || LFSR_TAP_B >= LFSR_W) begin : g_bad_tap
        $fatal(1, "cpu_io_hub_gen: LFSR taps must be below LFSR_W");
    end
    if (PRNG_OUT_LSB + DATA_W > LFSR_W) begin : g_bad_slice
        $fatal(1, "cpu_io_hub_gen: PRNG slice exceeds LFSR_W");
    end
    if (LFSR_DIV < 1 || DATA_W < 2 || ADDR_W <= 8) begin : g_bad_misc
        $fatal(1, "cpu_io_hub_gen: bad LFSR_DIV, DATA_W or ADDR_W");
    end

    localparam int PS_W = (LFSR_DIV > 1) ? $clog2(LFSR_DIV) : 1;

    logic                  page_hit, rd_sel;
    logic                  wq, wq1, wq2, wr_event, wr_bit;
    logic [7:0]            wr_ofs;
    logic [NUM_STROBE-1:0] strobe_nxt;
    logic [NUM_LATCH-1:0]  latch_nxt;
    logic                  run_nxt, busy_nxt, go, res, prng_run;
    logic                  done_sync, done_rise;
    logic [PS_W-1:0]       prescaler;
    logic                  tick;
    logic [LFSR_W-1:0]     lfsr;
    logic [DATA_W-1:0]     prng_q, rd_data, latch_rd;
    logic                  unused_bits;

    assign page_hit = (cpu_addr[ADDR_W-1:8] == BASE_ADDR[ADDR_W-1:8]);
    assign rd_sel   = cpu_rnw & page_hit;
    assign wq       = cpu_e & ~cpu_rnw & page_hit;
    assign wr_event = wq1 & ~wq2;
    assign tick     = (prescaler == PS_W'(LFSR_DIV - 1));

    assign unused_bits = ^{lfsr[LFSR_W-1], cpu_dout[DATA_W-2:0]};

    sync_rise #(.DEPTH(3)) u_done_sync (
        .clk_12  (clk_12),
        .reset_n (reset_n),
        .d       (done_in),
        .sync    (done_sync),
        .rise    (done_rise)
    );

    if (NUM_LATCH >= DATA_W) begin : g_latch_rd_wide
        assign latch_rd = latch_q[DATA_W-1:0];
    end else begin : g_latch_rd_pad
        assign latch_rd = {{(DATA_W - NUM_LATCH){1'b0}}, latch_q};
    end

    // wq1/wq2 come out of reset high so a window already open at release is
    // ignored; the next event needs wq1 to have been seen low first.
    always_ff @(posedge clk_12 or negedge reset_n) begin
        if (!reset_n) begin
            wq1    <= 1'b1;
            wq2    <= 1'b1;
            wr_ofs <= '0;
            wr_bit <= 1'b0;
        end else begin
            wq1 <= wq;
            wq2 <= wq1;
            if (wq && !wq1) begin
                wr_ofs <= cpu_addr[7:0];
                wr_bit <= cpu_dout[DATA_W-1];
            end
        end
    end

    always_comb begin
        strobe_nxt = '0;
        latch_nxt  = latch_q;
        run_nxt    = prng_run;
        for (int k = 0; k < NUM_STROBE; k++) begin
            if (wr_event && wr_ofs == OFS_STROBE + 8'(k)) strobe_nxt[k] = 1'b1;
        end
        for (int k = 0; k < NUM_LATCH; k++) begin
            if (wr_event && wr_ofs == OFS_LATCH + 8'(k)) latch_nxt[k] = wr_bit;
        end
        if (wr_event && wr_ofs == OFS_PRNG_CTL) run_nxt = wr_bit;
        go  = wr_event && (wr_ofs == OFS_STROBE);
        res = wr_event && (wr_ofs == OFS_STROBE + 8'd1) && (NUM_STROBE > 1);
        // A GO landing on the same edge as RES or a done edge wins.
        if (go) begin
            busy_nxt = 1'b1;
        end else if (res || done_rise) begin
            busy_nxt = 1'b0;
        end else begin
            busy_nxt = busy;
        end
    end

    always_comb begin
        rd_data = '0;
        case (cpu_addr[7:0])
            OFS_RD_PRNG:  rd_data = prng_q;
            OFS_RD_STAT: begin
                rd_data[DATA_W-1] = busy;
                rd_data[DATA_W-2] = done_sync;
            end
            OFS_RD_LATCH: rd_data = latch_rd;
            default:      rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_12 or negedge reset_n) begin
        if (!reset_n) begin
            strobe     <= '0;
            latch_q    <= '0;
            prng_run   <= 1'b0;
            busy       <= 1'b0;
            cpu_rd_hit <= 1'b0;
            cpu_din_q  <= '0;
        end else begin
            strobe     <= strobe_nxt;
            latch_q    <= latch_nxt;
            prng_run   <= run_nxt;
            busy       <= busy_nxt;
            cpu_rd_hit <= rd_sel;
            cpu_din_q  <= rd_sel ? rd_data : '0;
        end
    end

    // The PRNG slice is sampled before the shift on the same tick.
    always_ff @(posedge clk_12 or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
            lfsr      <= '1;
            prng_q    <= '1;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (!prng_run) begin
                lfsr <= '1;
            end else if (tick) begin
                lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B]};
            end
            if (tick) prng_q <= lfsr[PRNG_OUT_LSB +: DATA_W];
        end
    end

endmodule
